// File: rtl/ppu_layer_mixer.sv
// Two-stage priority compositor: picks the lowest-index enabled, non-key layer per pixel.
// Control registers are double-buffered and commit at pixel 0/0 or every cycle when immediate.
module ppu_layer_mixer #(
  parameter int unsigned NUM_LAYERS = 20,
  parameter int unsigned COLOR_W    = 24,
  parameter int unsigned IDX_W      = 5
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          write,
  input  logic [2:0]                    address,
  input  logic [31:0]                   writedata,
  input  logic [9:0]                    hcount,
  input  logic [9:0]                    vcount,
  input  logic [NUM_LAYERS*COLOR_W-1:0] layer_rgb,
  output logic [COLOR_W-1:0]            RGB_output,
  output logic                          hit,
  output logic [IDX_W-1:0]              hit_layer,
  output logic [9:0]                    hcount_out,
  output logic [9:0]                    vcount_out
);

  localparam logic [COLOR_W-1:0] DefColor = COLOR_W'(24'h202020);

  // Shadow (CPU-visible) and active (pipeline-visible) register sets
  logic [NUM_LAYERS-1:0] sh_mask_q, ac_mask_q, eff_mask;
  logic [COLOR_W-1:0]    sh_key_q, ac_key_q, eff_key;
  logic [COLOR_W-1:0]    sh_bg_q, ac_bg_q, eff_bg;
  logic                  sh_force_q, ac_force_q, eff_force;
  logic                  sh_imm_q, ac_imm_q, eff_imm;
  logic                  commit;

  // Bits of writedata beyond the register widths are intentionally discarded
  logic unused_wdata;
  assign unused_wdata = ^writedata;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sh_mask_q  <= '1;
      sh_key_q   <= DefColor;
      sh_bg_q    <= DefColor;
      sh_force_q <= 1'b0;
      sh_imm_q   <= 1'b0;
    end else if (write) begin
      case (address)
        3'd0: sh_mask_q <= writedata[NUM_LAYERS-1:0];
        3'd1: sh_key_q  <= writedata[COLOR_W-1:0];
        3'd2: sh_bg_q   <= writedata[COLOR_W-1:0];
        3'd3: begin
          sh_force_q <= writedata[0];
          sh_imm_q   <= writedata[1];
        end
        default: ;
      endcase
    end
  end

  // The pixel entering on a commit cycle already sees the freshly committed set
  assign commit    = ((hcount == 10'd0) && (vcount == 10'd0)) || ac_imm_q;
  assign eff_mask  = commit ? sh_mask_q  : ac_mask_q;
  assign eff_key   = commit ? sh_key_q   : ac_key_q;
  assign eff_bg    = commit ? sh_bg_q    : ac_bg_q;
  assign eff_force = commit ? sh_force_q : ac_force_q;
  assign eff_imm   = commit ? sh_imm_q   : ac_imm_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ac_mask_q  <= '1;
      ac_key_q   <= DefColor;
      ac_bg_q    <= DefColor;
      ac_force_q <= 1'b0;
      ac_imm_q   <= 1'b0;
    end else begin
      ac_mask_q  <= eff_mask;
      ac_key_q   <= eff_key;
      ac_bg_q    <= eff_bg;
      ac_force_q <= eff_force;
      ac_imm_q   <= eff_imm;
    end
  end

  // Stage 1: capture pixel data and per-layer opacity
  logic [NUM_LAYERS*COLOR_W-1:0] s1_rgb_q;
  logic [NUM_LAYERS-1:0]         s1_opaque_q, s1_opaque_d;
  logic [9:0]                    s1_hc_q, s1_vc_q;
  logic                          s1_force_q;
  logic [COLOR_W-1:0]            s1_bg_q;

  always_comb begin
    s1_opaque_d = '0;
    for (int i = 0; i < int'(NUM_LAYERS); i++) begin
      s1_opaque_d[i] = eff_mask[i] && (layer_rgb[i*COLOR_W +: COLOR_W] != eff_key);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      s1_rgb_q    <= '0;
      s1_opaque_q <= '0;
      s1_hc_q     <= '0;
      s1_vc_q     <= '0;
      s1_force_q  <= 1'b0;
      s1_bg_q     <= DefColor;
    end else begin
      s1_rgb_q    <= layer_rgb;
      s1_opaque_q <= s1_opaque_d;
      s1_hc_q     <= hcount;
      s1_vc_q     <= vcount;
      s1_force_q  <= eff_force;
      s1_bg_q     <= eff_bg;
    end
  end

  // Stage 2: lowest set opaque bit wins; scanning downward lets the lowest index overwrite
  logic [COLOR_W-1:0] rgb_q, rgb_d;
  logic               hit_q, hit_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic [9:0]         hc_q, vc_q;

  always_comb begin
    hit_d = 1'b0;
    idx_d = '0;
    rgb_d = s1_bg_q;
    for (int i = int'(NUM_LAYERS) - 1; i >= 0; i--) begin
      if (s1_opaque_q[i]) begin
        hit_d = 1'b1;
        idx_d = IDX_W'(i);
        rgb_d = s1_rgb_q[i*COLOR_W +: COLOR_W];
      end
    end
    if (s1_force_q || !hit_d) begin
      hit_d = 1'b0;
      idx_d = '0;
      rgb_d = s1_bg_q;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rgb_q <= DefColor;
      hit_q <= 1'b0;
      idx_q <= '0;
      hc_q  <= '0;
      vc_q  <= '0;
    end else begin
      rgb_q <= rgb_d;
      hit_q <= hit_d;
      idx_q <= idx_d;
      hc_q  <= s1_hc_q;
      vc_q  <= s1_vc_q;
    end
  end

  assign RGB_output = rgb_q;
  assign hit        = hit_q;
  assign hit_layer  = idx_q;
  assign hcount_out = hc_q;
  assign vcount_out = vc_q;

endmodule

// File: tb/tb_ppu_layer_mixer.sv
// Randomised plus directed bench for ppu_layer_mixer against a frame-level reference model.
module tb_ppu_layer_mixer;

  localparam int NL = 20;
  localparam int CW = 24;
  localparam int IW = 5;

  logic          clk, reset, write;
  logic [2:0]    address;
  logic [31:0]   writedata;
  logic [9:0]    hcount, vcount;
  logic [NL*CW-1:0] layer_rgb;
  logic [CW-1:0] RGB_output;
  logic          hit;
  logic [IW-1:0] hit_layer;
  logic [9:0]    hcount_out, vcount_out;

  ppu_layer_mixer #(.NUM_LAYERS(NL), .COLOR_W(CW), .IDX_W(IW)) dut (
    .clk       (clk),
    .reset     (reset),
    .write     (write),
    .address   (address),
    .writedata (writedata),
    .hcount    (hcount),
    .vcount    (vcount),
    .layer_rgb (layer_rgb),
    .RGB_output(RGB_output),
    .hit       (hit),
    .hit_layer (hit_layer),
    .hcount_out(hcount_out),
    .vcount_out(vcount_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [CW-1:0] rgb;
    logic          hit;
    logic [IW-1:0] idx;
    logic [9:0]    hc;
    logic [9:0]    vc;
  } exp_t;

  int checks = 0;
  int errors = 0;

  // Reference state: what software wrote, and what the current frame uses
  logic [31:0]   sh_mask, ac_mask;
  logic [CW-1:0] sh_key, ac_key, sh_bg, ac_bg;
  logic          sh_force, ac_force, sh_imm, ac_imm;
  exp_t          exp1, exp2;
  logic [NL*CW-1:0] lay;
  logic [CW-1:0] pal [5];

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s got %h expected %h at %0t", tag, got, want, $time);
    end
  endtask

  function automatic exp_t reset_exp();
    exp_t e;
    e.rgb = 24'h202020;
    e.hit = 1'b0;
    e.idx = '0;
    e.hc  = '0;
    e.vc  = '0;
    return e;
  endfunction

  task automatic model_reset();
    sh_mask = '1; ac_mask = '1;
    sh_key = 24'h202020; ac_key = 24'h202020;
    sh_bg = 24'h202020; ac_bg = 24'h202020;
    sh_force = 0; ac_force = 0; sh_imm = 0; ac_imm = 0;
    exp1 = reset_exp();
    exp2 = reset_exp();
  endtask

  function automatic exp_t mix(input logic [NL*CW-1:0] l, input logic [9:0] hc,
                               input logic [9:0] vc);
    exp_t e;
    e.rgb = ac_bg; e.hit = 0; e.idx = '0; e.hc = hc; e.vc = vc;
    if (!ac_force) begin
      for (int i = 0; i < NL; i++) begin
        if (ac_mask[i] && l[i*CW +: CW] != ac_key) begin
          e.rgb = l[i*CW +: CW]; e.hit = 1; e.idx = IW'(i);
          break;
        end
      end
    end
    return e;
  endfunction

  // One pixel clock: drive, advance model, compare output for the pixel two clocks old
  task automatic cycle(input logic wr, input logic [2:0] ad, input logic [31:0] wd,
                       input logic [9:0] hc, input logic [9:0] vc);
    exp_t now;
    write = wr; address = ad; writedata = wd; hcount = hc; vcount = vc; layer_rgb = lay;
    if ((hc == 0 && vc == 0) || ac_imm) begin
      ac_mask = sh_mask; ac_key = sh_key; ac_bg = sh_bg; ac_force = sh_force; ac_imm = sh_imm;
    end
    now = mix(lay, hc, vc);
    if (wr) begin
      case (ad)
        3'd0: sh_mask = wd;
        3'd1: sh_key = wd[CW-1:0];
        3'd2: sh_bg = wd[CW-1:0];
        3'd3: begin sh_force = wd[0]; sh_imm = wd[1]; end
        default: ;
      endcase
    end
    @(posedge clk);
    exp2 = exp1;
    exp1 = now;
    @(negedge clk);
    write = 0;
    check_eq("rgb", 32'(RGB_output), 32'(exp2.rgb));
    check_eq("hit", 32'(hit), 32'(exp2.hit));
    check_eq("idx", 32'(hit_layer), 32'(exp2.idx));
    check_eq("hcount_out", 32'(hcount_out), 32'(exp2.hc));
    check_eq("vcount_out", 32'(vcount_out), 32'(exp2.vc));
  endtask

  task automatic check_reset_outputs(input string tag);
    check_eq({tag, "_rgb"}, 32'(RGB_output), 32'h202020);
    check_eq({tag, "_hit"}, 32'(hit), 32'd0);
    check_eq({tag, "_idx"}, 32'(hit_layer), 32'd0);
    check_eq({tag, "_hc"}, 32'(hcount_out), 32'd0);
    check_eq({tag, "_vc"}, 32'(vcount_out), 32'd0);
  endtask

  task automatic mid_reset();
    reset = 1'b0;
    #1;
    check_reset_outputs("midreset");
    model_reset();
    @(negedge clk);
    reset = 1'b1;
  endtask

  task automatic fill_layers(input logic [CW-1:0] c);
    for (int i = 0; i < NL; i++) lay[i*CW +: CW] = c;
  endtask

  initial begin
    pal[0] = 24'h202020; pal[1] = 24'hFF0000; pal[2] = 24'h00FF00;
    pal[3] = 24'h0000FF; pal[4] = 24'h123456;
    reset = 0; write = 0; address = '0; writedata = '0; hcount = '0; vcount = '0;
    layer_rgb = '0;
    model_reset();
    fill_layers(24'h202020);
    repeat (2) @(negedge clk);
    check_reset_outputs("por");
    reset = 1;

    // Two visible layers, layer 3 has priority
    lay[3*CW +: CW] = 24'hFF0000;
    lay[14*CW +: CW] = 24'h00FF00;
    for (int i = 0; i < 3; i++) cycle(0, 0, 0, 10'd5, 10'd5);
    check_eq("tp1_rgb", 32'(RGB_output), 32'hFF0000);
    check_eq("tp1_hit", 32'(hit), 32'd1);
    check_eq("tp1_idx", 32'(hit_layer), 32'd3);

    // Mid-frame mask write takes effect only at the next 0/0
    cycle(1, 3'd0, 32'hFFFF_FFF7, 10'd100, 10'd50);
    for (int i = 0; i < 3; i++) cycle(0, 0, 0, 10'(101 + i), 10'd50);
    check_eq("tp2_hold", 32'(RGB_output), 32'hFF0000);
    cycle(0, 0, 0, 10'd0, 10'd0);
    cycle(0, 0, 0, 10'd1, 10'd0);
    cycle(0, 0, 0, 10'd2, 10'd0);
    check_eq("tp2_rgb", 32'(RGB_output), 32'h00FF00);
    check_eq("tp2_idx", 32'(hit_layer), 32'd14);

    // Immediate mode: key and background change without waiting for a frame
    cycle(1, 3'd3, 32'h2, 10'd3, 10'd0);
    cycle(0, 0, 0, 10'd0, 10'd0);
    cycle(1, 3'd1, 32'hFF0000, 10'd1, 10'd0);
    cycle(1, 3'd2, 32'h0000FF, 10'd2, 10'd0);
    fill_layers(24'hFF0000);
    for (int i = 0; i < 3; i++) cycle(0, 0, 0, 10'(3 + i), 10'd0);
    check_eq("tp3_rgb", 32'(RGB_output), 32'h0000FF);
    check_eq("tp3_hit", 32'(hit), 32'd0);
    check_eq("tp3_idx", 32'(hit_layer), 32'd0);

    // Force background
    cycle(1, 3'd3, 32'h1, 10'd9, 10'd0);
    for (int i = 0; i < NL; i++) lay[i*CW +: CW] = pal[i % 5];
    cycle(0, 0, 0, 10'd0, 10'd0);
    for (int i = 0; i < 3; i++) cycle(0, 0, 0, 10'(1 + i), 10'd0);
    check_eq("tp4_rgb", 32'(RGB_output), 32'h0000FF);
    check_eq("tp4_hit", 32'(hit), 32'd0);

    // Reset during streaming, then defaults are back in use
    mid_reset();
    fill_layers(24'h202020);
    lay[0 +: CW] = 24'h123456;
    lay[1*CW +: CW] = 24'hABCDEF;
    cycle(0, 0, 0, 10'd7, 10'd7);
    cycle(0, 0, 0, 10'd8, 10'd7);
    check_eq("tp6_rgb", 32'(RGB_output), 32'h123456);
    check_eq("tp6_hit", 32'(hit), 32'd1);

    // Mask written on the 0/0 cycle itself waits a whole frame
    cycle(1, 3'd0, 32'h2, 10'd0, 10'd0);
    cycle(0, 0, 0, 10'd1, 10'd0);
    check_eq("tp5_old_rgb", 32'(RGB_output), 32'h123456);
    check_eq("tp5_old_idx", 32'(hit_layer), 32'd0);
    cycle(0, 0, 0, 10'd0, 10'd0);
    cycle(0, 0, 0, 10'd1, 10'd0);
    check_eq("tp5_new_rgb", 32'(RGB_output), 32'hABCDEF);
    check_eq("tp5_new_idx", 32'(hit_layer), 32'd1);

    // Random traffic
    for (int n = 0; n < 1500; n++) begin
      logic          wr;
      logic [2:0]    ad;
      logic [31:0]   wd;
      logic [9:0]    hc, vc;
      wr = ($urandom % 4) == 0;
      ad = 3'($urandom % 8);
      wd = $urandom;
      if (ad == 3'd1 || ad == 3'd2) wd[CW-1:0] = pal[$urandom % 5];
      if (ad == 3'd3) wd[0] = ($urandom % 6) == 0;
      if (ad == 3'd0 && ($urandom % 2 == 0)) wd = wd | 32'hFFF0_0FF0;
      for (int i = 0; i < NL; i++) lay[i*CW +: CW] = pal[$urandom % 5];
      case ($urandom % 10)
        0: begin hc = 0; vc = 0; end
        1: begin hc = 0; vc = 10'($urandom); end
        2: begin hc = 10'($urandom); vc = 0; end
        default: begin hc = 10'($urandom); vc = 10'($urandom); end
      endcase
      cycle(wr, ad, wd, hc, vc);
      if (n == 700) mid_reset();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
